// File: rtl/mult_div_unit_if.sv
// Operand/command bus and HI/LO read-back between the execute-stage controller and mult_div_unit.
interface mult_div_unit_if;
  logic [31:0] MDU_Operand1;
  logic [31:0] MDU_Operand2;
  logic [3:0]  MDU_Operation;
  logic        MDU_Start;
  logic        MDU_WriteHI;
  logic        MDU_WriteLO;
  logic        MDU_Busy;
  logic [31:0] MDU_HI;
  logic [31:0] MDU_LO;

  modport master (
    output MDU_Operand1, MDU_Operand2, MDU_Operation, MDU_Start, MDU_WriteHI, MDU_WriteLO,
    input  MDU_Busy, MDU_HI, MDU_LO
  );

  modport slave (
    input  MDU_Operand1, MDU_Operand2, MDU_Operation, MDU_Start, MDU_WriteHI, MDU_WriteLO,
    output MDU_Busy, MDU_HI, MDU_LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO; results commit on the edge Busy falls.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (opcodes 4-7).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave mdu
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [3:0]         op_p0;
  logic [31:0]        a_p0;
  logic [31:0]        b_p0;
  logic               launch;

  function automatic logic op_legal(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return ~op[3];
`else
    return ~op[3] & ~op[2];
`endif
  endfunction

  assign launch = (state == IDLE) & mdu.MDU_Start & op_legal(mdu.MDU_Operation);

  // Stage p0: operands captured at launch, held stable for the whole run
  always_ff @(posedge clk) begin
    if (launch) begin
      op_p0 <= mdu.MDU_Operation;
      a_p0  <= mdu.MDU_Operand1;
      b_p0  <= mdu.MDU_Operand2;
    end
  end

  // Even opcodes are signed, odd ones unsigned, across all four op classes
  logic               is_signed;
  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic signed [63:0] prod;

  assign is_signed = ~op_p0[0];
  assign mul_a     = $signed({{32{is_signed & a_p0[31]}}, a_p0});
  assign mul_b     = $signed({{32{is_signed & b_p0[31]}}, b_p0});
  assign prod      = mul_a * mul_b;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign a_neg    = is_signed & a_p0[31];
  assign b_neg    = is_signed & b_p0[31];
  assign div_zero = (b_p0 == 32'd0);
  assign a_mag    = a_neg ? -a_p0 : a_p0;
  assign b_mag    = b_neg ? -b_p0 : b_p0;
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;

  logic        commit_en;
  logic [63:0] commit_val;

  always_comb begin
    commit_en  = 1'b1;
    commit_val = prod;
    case (op_p0[2:1])
      2'b00: commit_val = prod;
      2'b01: begin
        commit_val = {rem, quot};
        commit_en  = ~div_zero;
      end
`ifdef MDU_MADD_EN
      2'b10: commit_val = {hi, lo} + prod;
      2'b11: commit_val = {hi, lo} - prod;
`endif
      default: commit_en = 1'b0;
    endcase
  end

  // Stage p1: run counter and HI/LO commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            cnt   <= (mdu.MDU_Operation[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (mdu.MDU_WriteHI) hi <= mdu.MDU_Operand1;
            if (mdu.MDU_WriteLO) lo <= mdu.MDU_Operand1;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (commit_en) {hi, lo} <= commit_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu.MDU_Busy = busy;
  assign mdu.MDU_HI   = hi;
  assign mdu.MDU_LO   = lo;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit owning the HI/LO register pair; the sequential counterpart of the single-cycle ALU in the execute stage. It takes the same two 32-bit register operands the ALU takes, but runs MULT/MULTU/DIV/DIVU over several cycles behind a start/busy handshake. It returns results through HI/LO read ports instead of a same-cycle result bus. The pipeline controller stalls dependent instructions while the unit is busy.

## Interface
- MULT_CYCLES, 5, busy cycles for any multiply-class operation (≥1)
- DIV_CYCLES, 10, busy cycles for any divide-class operation (≥1)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- MDU_Operand1  input  32  rs value (multiplicand / dividend)
- MDU_Operand2  input  32  rt value (multiplier / divisor)
- MDU_Operation  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU; 8–15 no-op
- MDU_Start  input  1  launch MDU_Operation this cycle
- MDU_WriteHI  input  1  mthi: HI <= MDU_Operand1
- MDU_WriteLO  input  1  mtlo: LO <= MDU_Operand1
- MDU_Busy  output  1  registered; operation in flight
- MDU_HI  output  32  HI register
- MDU_LO  output  32  LO register

## Operation
- States: IDLE, RUN. Reset forces IDLE, counter 0, HI=LO=0, MDU_Busy=0.
- IDLE with Start=1 and opcode 0–7 (4–7 only if MADD feature built): latch operands and opcode, load counter with MULT_CYCLES or DIV_CYCLES, go RUN. Start with opcode 8–15: ignored, stay IDLE.
- RUN: counter decrements each cycle. On the edge where counter reaches terminal, commit HI/LO and return to IDLE.
- Start, WriteHI and WriteLO during RUN: ignored. The controller must stall them; the unit does not queue them.
- IDLE with WriteHI/WriteLO: write on that edge. Start takes priority over mthi/mtlo in the same cycle; the writes are dropped.
- MULT: {HI,LO} = signed 32×32→64. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with sign of dividend. DIVU: unsigned.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divisor 0 (DIV/DIVU): full DIV_CYCLES busy; HI/LO unchanged.
- Results are computed from operands latched at Start. Operand inputs may change during RUN without effect.

## Timing
- Start sampled at edge E. MDU_Busy=1 from E through edge E+L, for exactly L cycles, where L = MULT_CYCLES or DIV_CYCLES.
- HI/LO update on edge E+L, the same edge MDU_Busy falls. The first cycle with Busy=0 shows the new values.
- Back-to-back operations: a new Start is accepted in the first cycle after Busy falls.
- mthi/mtlo: HI/LO visible the cycle after the write edge.
- Reset asserted mid-RUN: the operation is aborted immediately (asynchronous). HI=LO=0, Busy=0, and no partial result commits.
- The controller stalls any mfhi/mflo/mult/div/mthi/mtlo when MDU_Busy | MDU_Start.

## Configuration
- MDU_MADD_EN defined: opcodes 4–7 are valid.
  - MADD/MADDU: {HI,LO} += signed/unsigned product.
  - MSUB/MSUBU: {HI,LO} -= product.
  - Accumulation is 64-bit modulo 2^64. The {HI,LO} used is the value at commit time. Latency is MULT_CYCLES.
- MDU_MADD_EN undefined: opcodes 4–7 are treated as no-ops (Start ignored, Busy stays 0); no accumulate datapath is built.

## Test plan
- Reset mid-run: DIV started, reset at cycle 3 -> Busy=0, HI=LO=0 immediately; no later commit.
- MULT 0xFFFFFFFE × 0x00000003 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 after mthi 0x11, mtlo 0x22 -> HI=0x11, LO=0x22 unchanged; Busy still 10 cycles.
- Overflow/edge cases: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Ignored requests: Start(MULT) held high during RUN, and mtlo pulsed during RUN -> neither takes effect. The first result equals the first operands' product, and a second op launches only when Start is sampled in IDLE.
- MDU_MADD_EN: after MULT 2×3, MADD 4×5 -> {HI,LO}=26; MSUBU 0xFFFFFFFF×1 -> {HI,LO}=0xFFFFFFFF_0000001B. Without the macro, MADD Start leaves Busy=0 and HI/LO unchanged.
